// File: rtl/isa_types_pkg.sv
// Shared ISA-level widths and the fetch buffer entry type.
package isa_types;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] bits;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: power-of-two ring of fetch entries with flush.
module fetch_fifo
  import isa_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  // Occupancy, flags and the accepted push/pop for this cycle.
  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    full_o  = (count == (AW+1)'(DEPTH));
    empty_o = (count == '0);
    do_pop  = pop_i && !empty_o && !flush_i;
    // A pop frees the slot the push writes, so full+pop+push is legal.
    do_push = push_i && (!full_o || do_pop) && !flush_i;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers; reset and flush both empty the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= entry_i;
  end

  assign head_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetcher: one outstanding fixed-latency read,
// results buffered in fetch_fifo, redirect flushes and restarts.
module fetch_unit
  import isa_types::*;
#(
  parameter int unsigned     READ_CYCLE_LATENCY = 2,
  parameter int unsigned     FIFO_DEPTH         = 2,
  parameter logic [XLEN-1:0] RESET_PC           = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr_bits,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned CNT_W =
    (READ_CYCLE_LATENCY < 1) ? 1 : $clog2(READ_CYCLE_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_CYCLE_LATENCY);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            push;
  logic            pop;
  logic            flush;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state: countdown, push on completion, stall in HOLD, redirect wins.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    flush      = 1'b0;
    pop        = instr_valid && instr_ready;
    push_entry = '{pc: pc_q, bits: mem_rdata};
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = align_pc(redirect_pc);
      cnt_d   = CNT_LOAD;
      state_d = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (!fifo_full || pop) begin
            push  = 1'b1;
            pc_d  = pc_q + XLEN'(4);
            cnt_d = CNT_LOAD;
          end else begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (pop) begin
            push    = 1'b1;
            pc_d    = pc_q + XLEN'(4);
            cnt_d   = CNT_LOAD;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State, fetch address and latency counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      cnt_q   <= CNT_LOAD;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_addr    = pc_q;
  assign instr_valid = !fifo_empty;
  assign instr_bits  = head.bits;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a transaction-level model.
module tb_fetch_unit;

  localparam int unsigned L = 2;
  localparam int unsigned D = 2;
  localparam logic [31:0] K = 32'hA5A50000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_bits;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int passed = 0;
  int total  = 0;

  // Reference model: queue of buffered pcs, next pc, edge index when
  // the in-flight read's data is available.
  logic [31:0] mq[$];
  logic [31:0] popped[$];
  logic [31:0] mpc;
  int unsigned e;
  int unsigned ready_at;

  // Memory: data is only correct once the address was stable L cycles.
  logic [31:0] last_addr;
  int          age = 0;

  fetch_unit #(
    .READ_CYCLE_LATENCY (L),
    .FIFO_DEPTH         (D),
    .RESET_PC           (32'h0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_bits     (instr_bits),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_addr === last_addr) age = age + 1;
    else age = 0;
    last_addr = mem_addr;
  end

  assign mem_rdata = (age >= int'(L)) ? (mem_addr ^ K) : 32'hDEADBEEF;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq.delete();
    popped.delete();
    mpc      = 32'h0;
    e        = 0;
    ready_at = L;
  endtask

  // Drive one cycle of inputs, advance DUT and model together.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    int sz;
    bit pop;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    @(posedge clock);
    sz  = mq.size();
    pop = rdy && (sz > 0);
    if (pop) popped.push_back(mq[0]);
    if (redir) begin
      mq.delete();
      mpc      = {rpc[31:2], 2'b00};
      ready_at = e + 1 + L;
    end else begin
      if (pop) void'(mq.pop_front());
      if (e >= ready_at && (sz < int'(D) || pop)) begin
        mq.push_back(mpc);
        mpc      = mpc + 32'd4;
        ready_at = e + 1 + L;
      end
    end
    e++;
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", instr_valid);
    else passed++;
    total++;
    if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h expected 00000000", mem_addr);
    else passed++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_startup();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, '0);
      total++;
      if (instr_valid !== (mq.size() > 0))
        $display("FAIL startup_valid cyc%0d: got %b expected %b", i, instr_valid, mq.size() > 0);
      else passed++;
      if (i == 3) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_bits !== 32'hA5A50000)
          $display("FAIL startup_first: got v=%b pc=%h bits=%h expected v=1 pc=00000000 bits=a5a50000",
                   instr_valid, instr_pc, instr_bits);
        else passed++;
      end
      if (i == 6 || i == 9) begin
        total++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'((i / 3 - 1) * 4))
          $display("FAIL startup_seq cyc%0d: got v=%b pc=%h expected pc=%h",
                   i, instr_valid, instr_pc, 32'((i / 3 - 1) * 4));
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    repeat (20) step(1'b0, 1'b0, '0);
    total++;
    if (int'(dut.u_fifo.count) !== 2) $display("FAIL bp_occupancy: got %0d expected 2", dut.u_fifo.count);
    else passed++;
    total++;
    if (mem_addr !== 32'h8) $display("FAIL bp_hold_addr: got %h expected 00000008", mem_addr);
    else passed++;
    total++;
    if (instr_pc !== 32'h0 || instr_valid !== 1'b1)
      $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=00000000", instr_valid, instr_pc);
    else passed++;
    popped.delete();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, '0);
      total++;
      if (instr_valid !== (mq.size() > 0) || (instr_valid && instr_pc !== mq[0]))
        $display("FAIL bp_drain cyc%0d: got v=%b pc=%h expected v=%b", i, instr_valid, instr_pc, mq.size() > 0);
      else passed++;
    end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (popped.size() <= i || popped[i] !== exp_pc)
        $display("FAIL bp_order%0d: got %h expected %h", i, (popped.size() > i) ? popped[i] : 32'hX, exp_pc);
      else passed++;
      exp_pc += 4;
    end
  endtask

  task automatic test_redirect();
    int guard;
    do_reset();
    guard = 0;
    while (mq.size() < 2 && guard < 20) begin
      step(1'b0, 1'b0, '0);
      guard++;
    end
    total++;
    if (guard >= 20 || !(e < ready_at))
      $display("FAIL redir_setup: got size=%0d expected 2 with read in flight", mq.size());
    else passed++;
    step(1'b0, 1'b1, 32'h103);
    total++;
    if (instr_valid !== 1'b0) $display("FAIL redir_flush: got %b expected 0", instr_valid);
    else passed++;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    total++;
    if (instr_valid !== 1'b0) $display("FAIL redir_early: got %b expected 0", instr_valid);
    else passed++;
    step(1'b1, 1'b0, '0);
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_bits !== 32'hA5A50100)
      $display("FAIL redir_target: got v=%b pc=%h bits=%h expected v=1 pc=00000100 bits=a5a50100",
               instr_valid, instr_pc, instr_bits);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pcs [3];
    exp_pcs[0] = 32'hFFFFFFF8;
    exp_pcs[1] = 32'hFFFFFFFC;
    exp_pcs[2] = 32'h0;
    step(1'b1, 1'b1, 32'hFFFFFFF8);
    popped.delete();
    repeat (12) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (popped.size() <= i || popped[i] !== exp_pcs[i])
        $display("FAIL wrap_pc%0d: got %h expected %h", i, (popped.size() > i) ? popped[i] : 32'hX, exp_pcs[i]);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (12) step(1'b0, 1'b0, '0);
    total++;
    if (instr_valid !== 1'b1 || mem_addr !== 32'h8)
      $display("FAIL ar_hold: got v=%b addr=%h expected v=1 addr=00000008", instr_valid, mem_addr);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'h0)
      $display("FAIL ar_immediate: got v=%b addr=%h expected v=0 addr=00000000", instr_valid, mem_addr);
    else passed++;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, '0);
      total++;
      if (instr_valid !== (i == 3))
        $display("FAIL ar_restart cyc%0d: got %b expected %b", i, instr_valid, i == 3);
      else passed++;
    end
    total++;
    if (instr_pc !== 32'h0 || instr_bits !== 32'hA5A50000)
      $display("FAIL ar_restart_entry: got pc=%h bits=%h expected pc=00000000 bits=a5a50000", instr_pc, instr_bits);
    else passed++;
  endtask

  task automatic test_random();
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      rdy   = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 49) == 0);
      rpc   = $urandom();
      step(rdy, redir, rpc);
      total++;
      if (instr_valid !== (mq.size() > 0))
        $display("FAIL rand_valid cyc%0d: got %b expected %b", i, instr_valid, mq.size() > 0);
      else passed++;
      if (mq.size() > 0) begin
        total++;
        if (instr_pc !== mq[0] || instr_bits !== (mq[0] ^ K))
          $display("FAIL rand_entry cyc%0d: got pc=%h bits=%h expected pc=%h bits=%h",
                   i, instr_pc, instr_bits, mq[0], mq[0] ^ K);
        else passed++;
      end
      total++;
      if (int'(dut.u_fifo.count) > int'(D) || int'(dut.u_fifo.count) !== mq.size())
        $display("FAIL rand_occupancy cyc%0d: got %0d expected %0d", i, dut.u_fifo.count, mq.size());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter READ_CYCLE_LATENCY, default 2, memory cycles from address-stable to data-valid.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 32'h0, first fetch address.
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 mem_addr  output  XLEN  read address to memory.
REQ-007 mem_rdata  input  XLEN  read data from memory.
REQ-008 instr_valid  output  1  head entry is valid.
REQ-009 instr_ready  input  1  hart accepts the head entry.
REQ-010 instr_bits  output  ILEN  head instruction word.
REQ-011 instr_pc  output  XLEN  address of the head instruction.
REQ-012 redirect_valid  input  1  flush buffer and restart fetch.
REQ-013 redirect_pc  input  XLEN  new fetch address.

Function
REQ-014 The FSM SHALL have states FETCH (read in flight, counter counting down) and HOLD (read complete, buffer full).
REQ-015 In FETCH, mem_addr SHALL equal fetch_pc and stay stable; the counter loads READ_CYCLE_LATENCY and decrements once per cycle.
REQ-016 When counter==0 in FETCH and the buffer is not full, or is full with a pop this cycle, {fetch_pc, mem_rdata} SHALL be pushed, fetch_pc += 4, and the counter reloaded.
REQ-017 When counter==0 and the buffer is full with no pop, the FSM SHALL enter HOLD with mem_addr and the counter held.
REQ-018 In HOLD, the first cycle with a pop SHALL push {fetch_pc, mem_rdata}, advance fetch_pc by 4, reload the counter and return to FETCH.
REQ-019 A pop occurs when instr_valid && instr_ready; instr_valid = buffer not empty; instr_bits/instr_pc = head entry.
REQ-020 A pushed entry SHALL become visible on instr_valid the cycle after the push (no bypass).
REQ-021 Push and pop in the same cycle SHALL be legal at any occupancy, including full.
REQ-022 fetch_pc + 4 SHALL wrap modulo 2^XLEN (32'hFFFFFFFC -> 32'h0).
REQ-023 redirect_valid SHALL take priority over push and pop: buffer emptied, fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}, counter reloaded, state FETCH, in-flight read discarded.
REQ-024 A pop coinciding with a redirect counts as accepted by the hart; no entry remains afterwards.
REQ-025 Only one memory read SHALL be outstanding at any time.
REQ-026 Steady-state throughput with instr_ready held high SHALL be one instruction per READ_CYCLE_LATENCY+1 cycles.

Reset
REQ-027 While reset is high: state FETCH, fetch_pc = RESET_PC, counter = READ_CYCLE_LATENCY, buffer empty, instr_valid = 0, mem_addr = RESET_PC.
REQ-028 Assertion mid-read or in HOLD SHALL discard all buffered and in-flight data immediately (asynchronously).
REQ-029 After deassertion, the first instr_valid SHALL occur READ_CYCLE_LATENCY+1 rising edges after the first active edge.

Structure
REQ-030 A fetch_entry_t struct {pc: XLEN, bits: ILEN} SHALL be added to package isa_types; XLEN/ILEN come from that package.
REQ-031 The buffer SHALL be a sub-module fetch_fifo (parameterised depth, push/pop/flush, full/empty flags).
REQ-032 The FSM state SHALL be a module-local enum; parameters stay module-local.

Verification (memory model: word at A = A ^ 32'hA5A50000, latency 2)
REQ-033 Reset release, instr_ready=1 -> instr_valid first high 3 edges later with pc 0x0, bits 0xA5A50000; then pc 0x4, 0x8 every 3 cycles.
REQ-034 instr_ready=0 for 20 cycles -> exactly 2 entries (pc 0x0, 0x4), FSM in HOLD, mem_addr = 0x8; raise ready -> pcs 0x0, 0x4, 0x8 in order, no gaps or duplicates.
REQ-035 redirect_pc 0x103 while 2 entries buffered and read in flight -> instr_valid low next cycle; next entry pc 0x100, bits 0xA5A50100, after 3 cycles.
REQ-036 redirect to 0xFFFFFFF8, ready=1 -> pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x0 in sequence.
REQ-037 Async reset asserted mid-cycle during HOLD -> instr_valid low before next edge; restart from pc 0x0 per REQ-033.
REQ-038 Random ready toggling, 1000 cycles -> delivered pcs strictly sequential, bits match model, occupancy never exceeds FIFO_DEPTH.
